// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the NeoGS multi-client DMA request arbiter.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_END = 2'd2
  } state_e;

  localparam int MAX_NCH = 8;

  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Rotating-priority finder: first asserted request at or after i_ptr, wrapping modulo NCH.
module dma_rr_pick
  import dma_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = ptr_width(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [PW-1:0]  o_idx,
  output logic           o_any
);

  // Scan from the farthest rotation back to the pointer so the nearest requester wins.
  always_comb begin : p_pick
    int c;
    c     = 0;
    o_idx = {PW{1'b0}};
    o_any = |i_req;
    for (int k = NCH - 1; k >= 0; k--) begin
      c     = (int'(i_ptr) + k) % NCH;
      o_idx = i_req[c] ? PW'(c) : o_idx;
    end
  end

endmodule

// File: rtl/dma_arbiter_mc.sv
// N-channel round-robin arbiter onto the single Z80-bus-takeover DMA port.
// Optional macro DMA_ARB_CH0_PRIO_EN gives channel 0 fixed top priority.
module dma_arbiter_mc
  import dma_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 22,
  parameter int DW  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_ch_req,
  input  logic [NCH-1:0]    i_ch_rnw,
  input  logic [NCH*AW-1:0] i_ch_addr,
  input  logic [NCH*DW-1:0] i_ch_wd,
  output logic [NCH-1:0]    o_ch_ack,
  output logic [NCH-1:0]    o_ch_end,
  output logic [DW-1:0]     o_ch_rd,
  output logic              o_dma_req,
  output logic              o_dma_rnw,
  output logic [AW-1:0]     o_dma_addr,
  output logic [DW-1:0]     o_dma_wd,
  input  logic              i_dma_ack,
  input  logic              i_dma_end,
  input  logic [DW-1:0]     i_dma_rd
);

  localparam int PW = ptr_width(NCH);

  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt, w_ptr_adv;
  logic [PW-1:0]   r_grant, w_grant_nxt;
  logic [PW-1:0]   w_win;
  logic            w_any, w_load;
  logic            r_dma_req, w_dma_req_nxt;
  logic            r_dma_rnw;
  logic [AW-1:0]   r_dma_addr;
  logic [DW-1:0]   r_dma_wd;
  logic [NCH-1:0]  r_ch_ack, w_ch_ack_nxt;
  logic [NCH-1:0]  r_ch_end, w_ch_end_nxt;
  logic [NCH-1:0]  w_grant_oh;
  logic [DW-1:0]   r_ch_rd, w_ch_rd_nxt;

`ifdef DMA_ARB_CH0_PRIO_EN
  logic [NCH-1:0] w_req_masked;
  logic [PW-1:0]  w_win_rr;
  logic           w_any_rr;

  // Rotation covers channels 1..NCH-1 only; channel 0 overrides it outright.
  assign w_req_masked = i_ch_req & ~NCH'(1'b1);

  dma_rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
    .i_req (w_req_masked),
    .i_ptr (r_ptr),
    .o_idx (w_win_rr),
    .o_any (w_any_rr)
  );

  assign w_win     = i_ch_req[0] ? {PW{1'b0}} : w_win_rr;
  assign w_any     = i_ch_req[0] | w_any_rr;
  assign w_ptr_adv = (r_grant == {PW{1'b0}}) ? r_ptr :
                     (r_grant == PW'(NCH - 1)) ? {PW{1'b0}} : r_grant + PW'(1);
`else
  dma_rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
    .i_req (i_ch_req),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign w_ptr_adv = (r_grant == PW'(NCH - 1)) ? {PW{1'b0}} : r_grant + PW'(1);
`endif

  assign w_grant_oh = NCH'(1'b1) << r_grant;

  // Next-state and next-output decode for the IDLE/ISSUE/WAIT_END handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_load        = 1'b0;
    w_dma_req_nxt = r_dma_req;
    w_ch_ack_nxt  = {NCH{1'b0}};
    w_ch_end_nxt  = {NCH{1'b0}};
    w_ch_rd_nxt   = r_ch_rd;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt   = ST_ISSUE;
          w_grant_nxt   = w_win;
          w_load        = 1'b1;
          w_dma_req_nxt = 1'b1;
        end else begin
          w_dma_req_nxt = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (i_dma_ack) begin
          w_dma_req_nxt = 1'b0;
          w_ch_ack_nxt  = w_grant_oh;
          if (i_dma_end) begin
            w_ch_end_nxt = w_grant_oh;
            w_ch_rd_nxt  = i_dma_rd;
            w_ptr_nxt    = w_ptr_adv;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_state_nxt  = ST_WAIT_END;
          end
        end else begin
          w_dma_req_nxt = 1'b1;
        end
      end
      ST_WAIT_END: begin
        if (i_dma_end) begin
          w_ch_end_nxt = w_grant_oh;
          w_ch_rd_nxt  = i_dma_rd;
          w_ptr_nxt    = w_ptr_adv;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt  = ST_WAIT_END;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_dma_req_nxt = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs; request fields are captured only at grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= {PW{1'b0}};
      r_grant    <= {PW{1'b0}};
      r_dma_req  <= 1'b0;
      r_dma_rnw  <= 1'b0;
      r_dma_addr <= {AW{1'b0}};
      r_dma_wd   <= {DW{1'b0}};
      r_ch_ack   <= {NCH{1'b0}};
      r_ch_end   <= {NCH{1'b0}};
      r_ch_rd    <= {DW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_dma_req  <= w_dma_req_nxt;
      r_ch_ack   <= w_ch_ack_nxt;
      r_ch_end   <= w_ch_end_nxt;
      r_ch_rd    <= w_ch_rd_nxt;
      if (w_load) begin
        r_dma_rnw  <= i_ch_rnw[w_win];
        r_dma_addr <= i_ch_addr[w_win*AW +: AW];
        r_dma_wd   <= i_ch_wd[w_win*DW +: DW];
      end
    end
  end

  assign o_ch_ack   = r_ch_ack;
  assign o_ch_end   = r_ch_end;
  assign o_ch_rd    = r_ch_rd;
  assign o_dma_req  = r_dma_req;
  assign o_dma_rnw  = r_dma_rnw;
  assign o_dma_addr = r_dma_addr;
  assign o_dma_wd   = r_dma_wd;

endmodule

// File: tb/tb_dma_arbiter_mc.sv
// Randomised self-checking bench for dma_arbiter_mc against a transaction-level arbitration model.
module tb_dma_arbiter_mc;

  localparam int NCH = 4;
  localparam int AW  = 22;
  localparam int DW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_req, ch_rnw;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wd;
  logic [NCH-1:0]    ch_ack, ch_end;
  logic [DW-1:0]     ch_rd, dma_wd, dma_rd;
  logic              dma_req, dma_rnw, dma_ack, dma_end;
  logic [AW-1:0]     dma_addr;

  logic [AW-1:0] a [NCH];
  logic          r [NCH];
  logic [DW-1:0] d [NCH];

  int checks   = 0;
  int failures = 0;
  int mptr     = 0;

  dma_arbiter_mc #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_ch_req(ch_req), .i_ch_rnw(ch_rnw),
    .i_ch_addr(ch_addr), .i_ch_wd(ch_wd), .o_ch_ack(ch_ack), .o_ch_end(ch_end),
    .o_ch_rd(ch_rd), .o_dma_req(dma_req), .o_dma_rnw(dma_rnw), .o_dma_addr(dma_addr),
    .o_dma_wd(dma_wd), .i_dma_ack(dma_ack), .i_dma_end(dma_end), .i_dma_rd(dma_rd)
  );

  always #5 clk = ~clk;

  // Arbitration rule: first requester at or after the pointer, modulo NCH.
  function automatic int model_pick(input logic [NCH-1:0] v, input int p);
`ifdef DMA_ARB_CH0_PRIO_EN
    if (v[0]) return 0;
    for (int k = 0; k < NCH; k++) if (((p + k) % NCH) != 0 && v[(p + k) % NCH]) return (p + k) % NCH;
`else
    for (int k = 0; k < NCH; k++) if (v[(p + k) % NCH]) return (p + k) % NCH;
`endif
    return -1;
  endfunction

  function automatic int model_next_ptr(input int w, input int p);
`ifdef DMA_ARB_CH0_PRIO_EN
    if (w == 0) return p;
`endif
    return (w + 1) % NCH;
  endfunction

  function automatic int chan_of(input logic [AW-1:0] addr);
    for (int i = 0; i < NCH; i++) if (a[i] == addr) return i;
    return -1;
  endfunction

  function automatic logic [NCH-1:0] oh(input int i);
    logic [NCH-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_fields();
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*AW +: AW] = a[i];
      ch_rnw[i]           = r[i];
      ch_wd[i*DW +: DW]   = d[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NCH; i++) begin
      a[i] = {20'($urandom), 2'(i)};
      r[i] = 1'($urandom);
      d[i] = 8'($urandom);
    end
    apply_fields();
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_req = '0; dma_ack = 1'b0; dma_end = 1'b0; dma_rd = '0;
    rand_fields();
    tick(); tick();
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dma_req === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dma_req, dma_rnw, dma_addr, dma_wd} !== '0) begin
      failures++; $display("FAIL reset_dma got=%h req=0", {dma_req, dma_rnw, dma_addr, dma_wd});
    end
    checks++;
    if ({ch_ack, ch_end, ch_rd} !== '0) begin
      failures++; $display("FAIL reset_ch got=%h req=0", {ch_ack, ch_end, ch_rd});
    end
  endtask

  task automatic test_single();
    do_reset();
    a[2] = 22'h12345; r[2] = 1'b1; apply_fields();
    ch_req = 4'b0100;
    tick();
    checks++;
    if (dma_req !== 1'b1 || dma_addr !== 22'h12345 || dma_rnw !== 1'b1) begin
      failures++; $display("FAIL single_issue got req=%b addr=%h rnw=%b req 1/12345/1", dma_req, dma_addr, dma_rnw);
    end
    tick(); tick();
    checks++;
    if (dma_req !== 1'b1 || ch_ack !== 4'b0000) begin
      failures++; $display("FAIL single_hold got req=%b ack=%b req 1/0000", dma_req, ch_ack);
    end
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0; ch_req = 4'b0000;
    checks++;
    if (ch_ack !== 4'b0100 || dma_req !== 1'b0) begin
      failures++; $display("FAIL single_ack got ack=%b req=%b req 0100/0", ch_ack, dma_req);
    end
    tick(); tick();
    dma_end = 1'b1; dma_rd = 8'hA5;
    tick();
    dma_end = 1'b0;
    checks++;
    if (ch_end !== 4'b0100 || ch_rd !== 8'hA5 || ch_ack !== 4'b0000) begin
      failures++; $display("FAIL single_end got end=%b rd=%h ack=%b req 0100/a5/0000", ch_end, ch_rd, ch_ack);
    end
    tick();
    checks++;
    if (ch_end !== 4'b0000 || ch_rd !== 8'hA5) begin
      failures++; $display("FAIL single_after got end=%b rd=%h req 0000/a5", ch_end, ch_rd);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int g, expc;
    logic [DW-1:0] rd;
    do_reset();
    ch_req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_req(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL fair_timeout got no dma_req req grant %0d", n); end
      expc = model_pick(4'b1111, mptr);
      g = chan_of(dma_addr);
      checks++;
      if (g !== expc || dma_wd !== d[expc] || dma_rnw !== r[expc]) begin
        failures++; $display("FAIL fair_grant n=%0d got=%0d req=%0d", n, g, expc);
      end
      rd = 8'($urandom);
      dma_ack = 1'b1; dma_end = 1'b1; dma_rd = rd;
      tick();
      dma_ack = 1'b0; dma_end = 1'b0;
      checks++;
      if (ch_ack !== oh(expc) || ch_end !== oh(expc) || ch_rd !== rd || dma_req !== 1'b0) begin
        failures++; $display("FAIL fair_done got ack=%b end=%b rd=%h req oh=%b rd=%h", ch_ack, ch_end, ch_rd, oh(expc), rd);
      end
      mptr = model_next_ptr(expc, mptr);
      tick();
      checks++;
      if (dma_req !== 1'b1) begin
        failures++; $display("FAIL fair_b2b got dma_req=%b req 1", dma_req);
      end
    end
  endtask

  task automatic test_ack_end_same();
    do_reset();
    r[1] = 1'b0; d[1] = 8'h3C; apply_fields();
    ch_req = 4'b0010;
    tick();
    checks++;
    if (dma_req !== 1'b1 || dma_wd !== 8'h3C || dma_rnw !== 1'b0) begin
      failures++; $display("FAIL same_issue got req=%b wd=%h rnw=%b req 1/3c/0", dma_req, dma_wd, dma_rnw);
    end
    ch_req = 4'b0000;
    dma_ack = 1'b1; dma_end = 1'b1; dma_rd = 8'h77;
    tick();
    dma_ack = 1'b0; dma_end = 1'b0;
    checks++;
    if (ch_ack !== 4'b0010 || ch_end !== 4'b0010 || dma_wd !== 8'h3C || ch_rd !== 8'h77) begin
      failures++; $display("FAIL same_pulse got ack=%b end=%b wd=%h rd=%h req 0010/0010/3c/77", ch_ack, ch_end, dma_wd, ch_rd);
    end
    ch_req = 4'b0001;
    tick();
    checks++;
    if (ch_ack !== 4'b0000 || ch_end !== 4'b0000 || dma_req !== 1'b1 || chan_of(dma_addr) !== 0) begin
      failures++; $display("FAIL same_idle got ack=%b end=%b req=%b ch=%0d req 0000/0000/1/0", ch_ack, ch_end, dma_req, chan_of(dma_addr));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_req = 4'b0010;
    tick();
    ch_req = 4'b0000;
    dma_ack = 1'b1; dma_end = 1'b1; tick(); dma_ack = 1'b0; dma_end = 1'b0;
    tick();
    ch_req = 4'b0100;
    tick();
    ch_req = 4'b0000;
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    mptr = 0;
    checks++;
    if (dma_req !== 1'b0 || ch_end !== 4'b0000) begin
      failures++; $display("FAIL rstmid_state got req=%b end=%b req 0/0000", dma_req, ch_end);
    end
    dma_end = 1'b1; tick(); dma_end = 1'b0;
    checks++;
    if (ch_end !== 4'b0000 || dma_req !== 1'b0) begin
      failures++; $display("FAIL rstmid_late_end got end=%b req=%b req 0000/0", ch_end, dma_req);
    end
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    checks++;
    if (ch_ack !== 4'b0000 || dma_req !== 1'b0) begin
      failures++; $display("FAIL rstmid_late_ack got ack=%b req=%b req 0000/0", ch_ack, dma_req);
    end
    ch_req = 4'b1001;
    tick();
    checks++;
    if (dma_req !== 1'b1 || chan_of(dma_addr) !== model_pick(4'b1001, mptr)) begin
      failures++; $display("FAIL rstmid_ptr got ch=%0d req=%0d", chan_of(dma_addr), model_pick(4'b1001, mptr));
    end
    ch_req = 4'b0000;
    dma_ack = 1'b1; dma_end = 1'b1; tick(); dma_ack = 1'b0; dma_end = 1'b0;
    ch_req = 4'b1000;
    tick(); tick();
    checks++;
    if (dma_req !== 1'b1 || chan_of(dma_addr) !== 3) begin
      failures++; $display("FAIL rstmid_ch3 got req=%b ch=%0d req 1/3", dma_req, chan_of(dma_addr));
    end
    ch_req = 4'b0000;
  endtask

  task automatic test_spurious();
    do_reset();
    dma_end = 1'b1; dma_rd = 8'h5A; tick(); dma_end = 1'b0;
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    checks++;
    if (ch_end !== 4'b0000 || ch_ack !== 4'b0000 || ch_rd !== 8'h00 || dma_req !== 1'b0) begin
      failures++; $display("FAIL spur_idle got end=%b ack=%b rd=%h req=%b req 0/0/00/0", ch_end, ch_ack, ch_rd, dma_req);
    end
    ch_req = 4'b0001; tick(); ch_req = 4'b0000;
    dma_end = 1'b1; tick(); dma_end = 1'b0;
    checks++;
    if (ch_end !== 4'b0000 || dma_req !== 1'b1) begin
      failures++; $display("FAIL spur_issue_end got end=%b req=%b req 0000/1", ch_end, dma_req);
    end
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    checks++;
    if (ch_ack !== 4'b0001) begin
      failures++; $display("FAIL spur_ack got ack=%b req 0001", ch_ack);
    end
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    checks++;
    if (ch_ack !== 4'b0000 || ch_end !== 4'b0000) begin
      failures++; $display("FAIL spur_wait_ack got ack=%b end=%b req 0000/0000", ch_ack, ch_end);
    end
    dma_end = 1'b1; dma_rd = 8'hC3; tick(); dma_end = 1'b0;
    checks++;
    if (ch_end !== 4'b0001 || ch_rd !== 8'hC3) begin
      failures++; $display("FAIL spur_end got end=%b rd=%h req 0001/c3", ch_end, ch_rd);
    end
  endtask

  task automatic test_random();
    int expc, both;
    logic [NCH-1:0] v;
    logic [DW-1:0] rd;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      rand_fields();
      v = NCH'($urandom_range(1, 15));
      ch_req = v;
      tick();
      ch_req = '0;
      expc = model_pick(v, mptr);
      checks++;
      if (dma_req !== 1'b1 || chan_of(dma_addr) !== expc || dma_rnw !== r[expc] || dma_wd !== d[expc]) begin
        failures++; $display("FAIL rand_grant n=%0d v=%b got ch=%0d req=%0d", n, v, chan_of(dma_addr), expc);
      end
      repeat ($urandom_range(0, 2)) tick();
      both = int'($urandom_range(0, 1));
      rd = 8'($urandom);
      dma_ack = 1'b1; dma_end = 1'(both); dma_rd = rd;
      tick();
      dma_ack = 1'b0; dma_end = 1'b0;
      checks++;
      if (ch_ack !== oh(expc) || ch_end !== (both != 0 ? oh(expc) : 4'b0000)) begin
        failures++; $display("FAIL rand_ack n=%0d got ack=%b end=%b req oh=%b both=%0d", n, ch_ack, ch_end, oh(expc), both);
      end
      if (both == 0) begin
        repeat ($urandom_range(0, 2)) tick();
        dma_end = 1'b1; dma_rd = rd;
        tick();
        dma_end = 1'b0;
        checks++;
        if (ch_end !== oh(expc) || ch_ack !== 4'b0000) begin
          failures++; $display("FAIL rand_end n=%0d got end=%b ack=%b req %b/0000", n, ch_end, ch_ack, oh(expc));
        end
      end
      checks++;
      if (ch_rd !== rd || dma_req !== 1'b0) begin
        failures++; $display("FAIL rand_rd n=%0d got rd=%h req=%b req %h/0", n, ch_rd, dma_req, rd);
      end
      mptr = model_next_ptr(expc, mptr);
      tick();
    end
  endtask

`ifdef DMA_ARB_CH0_PRIO_EN
  task automatic test_prio();
    bit ok;
    int order [8] = '{0, 0, 0, 0, 1, 2, 3, 1};
    do_reset();
    ch_req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_req(ok);
      checks++;
      if (!ok || chan_of(dma_addr) !== order[n]) begin
        failures++; $display("FAIL prio_grant n=%0d got=%0d req=%0d", n, chan_of(dma_addr), order[n]);
      end
      dma_ack = 1'b1; dma_end = 1'b1;
      tick();
      dma_ack = 1'b0; dma_end = 1'b0;
      if (n == 3) ch_req = 4'b1110;
    end
    ch_req = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_ack_end_same();
    test_reset_mid();
    test_spurious();
    test_random();
`ifdef DMA_ARB_CH0_PRIO_EN
    test_prio();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_arbiter_mc.md
Name: dma_arbiter_mc

Overview:
- N-channel DMA request arbiter for the NeoGS memory DMA path.
- Merges up to NCH independent DMA clients (ZX-bus DMA, SD-card DMA, MP3 data DMA, ...) onto the single req/ack/end port of the existing Z80-bus-takeover DMA engine.
- Successor to the current single-client point-to-point hookup: parametrised channel count, address and data width, plus round-robin fairness.
- One transfer is in flight at a time. Request fields are registered at grant, so downstream sees stable values.

Parameters:
- NCH, 4, number of client channels (1..8)
- AW, 22, DMA byte address width (22 = 4 MB space)
- DW, 8, data width

Ports:
- clk  in  1  system clock (Z80/FPGA clock domain)
- rst  in  1  synchronous reset, active-high
- ch_req  in  NCH  per-channel request level; fields must be stable while high
- ch_rnw  in  NCH  per-channel 1=read, 0=write
- ch_addr  in  NCH*AW  flattened addresses; channel i at [i*AW +: AW]
- ch_wd  in  NCH*DW  flattened write data; channel i at [i*DW +: DW]
- ch_ack  out  NCH  one-cycle pulse: request of channel i accepted
- ch_end  out  NCH  one-cycle pulse: transfer of channel i complete
- ch_rd  out  DW  read data, valid in the ch_end cycle (shared by all channels)
- dma_req  out  1  downstream request
- dma_rnw  out  1  downstream direction
- dma_addr  out  AW  downstream address
- dma_wd  out  DW  downstream write data
- dma_ack  in  1  downstream accept pulse
- dma_end  in  1  downstream completion pulse
- dma_rd  in  DW  downstream read data, valid with dma_end

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant=0, all outputs 0 (dma_addr, dma_wd, ch_rd included).
- State IDLE, when any ch_req is high:
  - pick winner g = first requesting channel at or after rr_ptr, wrapping modulo NCH;
  - next cycle: dma_req=1; dma_rnw/dma_addr/dma_wd registered from channel g; grant=g; go to ISSUE.
  - Latency from ch_req to dma_req is one cycle.
- State ISSUE:
  - dma_req held at 1 until dma_ack is sampled high.
  - On dma_ack: next cycle dma_req=0, ch_ack[g]=1 for one cycle, go to WAIT_END.
- State WAIT_END:
  - On dma_end: next cycle ch_end[g]=1 for one cycle; ch_rd=dma_rd (held until the next end); rr_ptr=(g+1) mod NCH; go to IDLE.
  - ch_rd is updated for writes too (don't-care content).
- dma_ack and dma_end high in the same cycle in ISSUE: ch_ack[g] and ch_end[g] pulse together next cycle; go directly to IDLE.
- dma_end in IDLE or ISSUE without a prior ack: ignored.
- dma_ack outside ISSUE: ignored.
- Channel dropping ch_req while in ISSUE/WAIT_END: the transfer is already committed and completes normally; the channel must tolerate the resulting ack/end pulses.
- Channel re-requesting immediately after its own ch_end: loses to any other requester because of the rotation. With NCH requesters all continuously active, grants cycle 0,1,2,...,NCH-1,0.
- Back-to-back: new grant can issue at the earliest in the cycle after ch_end (IDLE lasts at least one cycle).
- Reset mid-transfer: immediate return to IDLE with dma_req=0; any late dma_ack/dma_end is ignored.
- NCH=1: rr_ptr is a constant 0; behaviour is otherwise identical.
- rr_ptr width = max(1, clog2(NCH)).

Optional Feature:
- Macro DMA_ARB_CH0_PRIO_EN.
- Defined: channel 0 has fixed top priority at each IDLE decision and wins whenever ch_req[0]=1. rr_ptr applies only among channels 1..NCH-1; a ch0 grant does not advance rr_ptr.
- Not defined: pure round-robin over all channels as above.

Decomposition:
- Package dma_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_END), 2-bit encoding;
  - MAX_NCH=8;
  - function for pointer width.
- Sub-module dma_rr_pick: combinational rotating priority finder; inputs req vector and rr_ptr; outputs winner index and any_req. Reused by the optional priority path with channel 0 masked.

Test Plan:
- Single channel: ch_req[2]=1, addr=0x12345, rnw=1; dma_ack at +3, dma_end with dma_rd=0xA5 at +6 -> dma_req high from +1 through the ack cycle; dma_addr=0x12345; ch_ack[2] at +4; ch_end[2] at +7; ch_rd=0xA5.
- Fairness: ch_req=4'b1111 held, downstream acks/ends immediately -> grant order 0,1,2,3,0,1; no channel granted twice before all others are served.
- Simultaneous ack+end in ISSUE (write, wd=0x3C) -> ch_ack[g] and ch_end[g] in the same cycle; dma_wd=0x3C throughout; back to IDLE in one cycle.
- Reset mid-transfer: rst in WAIT_END, then dma_end pulse -> no ch_end; dma_req=0; rr_ptr=0; next request from ch3 is granted normally.
- Spurious inputs: dma_end in IDLE, dma_ack in WAIT_END -> no ch_ack/ch_end pulses; state unchanged.
- With DMA_ARB_CH0_PRIO_EN: ch_req=4'b1111 held -> channel 0 is granted on every decision. Then drop ch_req[0] -> grants rotate 1,2,3,1.
